// File: rtl/board_test_gen2.sv
// board_test_gen2: CPLD test-board bring-up block (prescaler, event counter, registered adder)
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   en, clear           prescaler enable, synchronous clear of both counters
//   mode, load_val      event counter mode (00 up, 01 down, 10 hold, 11 load) and load value
//   add_a, add_b        adder operands, qualified by add_valid
//   counter_out, tick   prescaler count and combinational terminal pulse
//   small_out           event counter value; small_wrap is a one-cycle wrap pulse
//   sum_out, sum_valid  registered sum with carry in the MSB, and its valid flag
module board_test_gen2 #(
   parameter int CNT_W   = 15,
   parameter int TERM    = 2**CNT_W-1,
   parameter int SMALL_W = 4,
   parameter int ADD_W   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               clear,
   input  logic [1:0]         mode,
   input  logic [SMALL_W-1:0] load_val,
   input  logic [ADD_W-1:0]   add_a,
   input  logic [ADD_W-1:0]   add_b,
   input  logic               add_valid,
   output logic [CNT_W-1:0]   counter_out,
   output logic               tick,
   output logic [SMALL_W-1:0] small_out,
   output logic               small_wrap,
   output logic [ADD_W:0]     sum_out,
   output logic               sum_valid
);
   localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SMALL_W-1:0] small_q, small_d;
   logic               wrap_q, wrap_d;
   logic [ADD_W:0]     sum_q, sum_d;
   logic               sv_q;
   logic               up, dn, ld;
   assign tick = en & (cnt_q == TERM_C);
   assign ld   = mode == 2'b11;
   assign up   = mode == 2'b00 & tick;
   assign dn   = mode == 2'b01 & tick;
   always_comb begin
      cnt_d   = clear ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + CNT_W'(1);
      // load ignores en and tick; clear still beats it
      small_d = clear ? '0 : ld ? load_val : up ? small_q + SMALL_W'(1) :
                dn ? small_q - SMALL_W'(1) : small_q;
      wrap_d  = !clear & ((up & (&small_q)) | (dn & (small_q == '0)));
      sum_d   = add_valid ? {1'b0, add_a} + {1'b0, add_b} : sum_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q   <= '0;
         small_q <= '0;
         wrap_q  <= 1'b0;
         sum_q   <= '0;
         sv_q    <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         small_q <= small_d;
         wrap_q  <= wrap_d;
         sum_q   <= sum_d;
         sv_q    <= add_valid;
      end
   end
   assign counter_out = cnt_q;
   assign small_out   = small_q;
   assign small_wrap  = wrap_q;
   assign sum_out     = sum_q;
   assign sum_valid   = sv_q;
endmodule

// File: tb/tb_board_test_gen2.sv
// tb_board_test_gen2: directed self-checking bench, two instances (TERM=4 and TERM=7) sharing inputs
module tb_board_test_gen2;
   localparam int CW = 3;
   localparam int SW = 2;
   localparam int AW = 4;
   logic clk = 1'b0;
   logic reset, en, clear, add_valid;
   logic [1:0] mode;
   logic [SW-1:0] load_val;
   logic [AW-1:0] add_a, add_b;
   logic [CW-1:0] cnt_a, cnt_b;
   logic tick_a, tick_b, wrap_a, wrap_b, sv_a, sv_b;
   logic [SW-1:0] small_a, small_b;
   logic [AW:0] sum_a, sum_b;
   int n_chk = 0;
   int n_fail = 0;

   board_test_gen2 #(.CNT_W(CW), .TERM(4), .SMALL_W(SW), .ADD_W(AW)) dut_a (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode), .load_val(load_val),
      .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
      .counter_out(cnt_a), .tick(tick_a), .small_out(small_a), .small_wrap(wrap_a),
      .sum_out(sum_a), .sum_valid(sv_a));
   board_test_gen2 #(.CNT_W(CW), .TERM(7), .SMALL_W(SW), .ADD_W(AW)) dut_b (
      .clk(clk), .reset(reset), .en(en), .clear(clear), .mode(mode), .load_val(load_val),
      .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
      .counter_out(cnt_b), .tick(tick_b), .small_out(small_b), .small_wrap(wrap_b),
      .sum_out(sum_b), .sum_valid(sv_b));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int ca, input int cb, input int sa, input int sb,
                          input int wa, input int wb);
      check({tag, " cnt_a"}, 32'(cnt_a), ca);
      check({tag, " cnt_b"}, 32'(cnt_b), cb);
      check({tag, " small_a"}, 32'(small_a), sa);
      check({tag, " small_b"}, 32'(small_b), sb);
      check({tag, " wrap_a"}, 32'(wrap_a), wa);
      check({tag, " wrap_b"}, 32'(wrap_b), wb);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; clear = 1'b0; mode = 2'b00; load_val = '0;
      add_a = '0; add_b = '0; add_valid = 1'b0;
      #2;
      chk_cnt("reset", 0, 0, 0, 0, 0, 0);
      check("reset sum", 32'(sum_a), 0);
      check("reset sum_valid", 32'(sv_a), 0);
      @(negedge clk);
      reset = 1'b1; en = 1'b1;
      // up count: TERM=4 ticks on edges 5,10,..; TERM=7 on edges 8,16,..
      for (int k = 1; k <= 37; k++) begin
         step();
         chk_cnt("up", k % 5, k % 8, (k / 5) % 4, (k / 8) % 4, int'(k == 20), int'(k == 32));
         check("up tick_a", 32'(tick_a), int'(k % 5 == 4));
         check("up tick_b", 32'(tick_b), int'(k % 8 == 7));
      end
      check("idle sum_valid", 32'(sv_a), 0);
      en = 1'b0;
      #1 check("en0 tick_a", 32'(tick_a), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk_cnt("en0 hold", 2, 5, 3, 0, 0, 0);
      end
      mode = 2'b11; load_val = 2'd2;
      step();
      chk_cnt("load en0", 2, 5, 2, 2, 0, 0);
      mode = 2'b10; add_a = 4'd15; add_b = 4'd1; add_valid = 1'b1;
      step();
      check("add 15+1", 32'(sum_a), 16);
      check("add valid", 32'(sv_a), 1);
      add_valid = 1'b0;
      step();
      check("add hold", 32'(sum_a), 16);
      check("add invalid", 32'(sv_a), 0);
      add_a = 4'd3; add_b = 4'd4; add_valid = 1'b1;
      step();
      check("stream 3+4", 32'(sum_a), 7);
      check("stream v1", 32'(sv_a), 1);
      add_a = 4'd7; add_b = 4'd9;
      step();
      check("stream 7+9", 32'(sum_b), 16);
      check("stream v2", 32'(sv_b), 1);
      add_valid = 1'b0;
      step();
      chk_cnt("mode hold", 2, 5, 2, 2, 0, 0);
      // asynchronous reset, away from any clock edge
      #3 reset = 1'b0;
      #1;
      chk_cnt("async rst", 0, 0, 0, 0, 0, 0);
      check("async rst sum", 32'(sum_a), 0);
      check("async rst sv", 32'(sv_a), 0);
      step();
      chk_cnt("rst held", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b1; en = 1'b1; mode = 2'b01;
      for (int k = 1; k <= 9; k++) begin
         step();
         chk_cnt("down", k % 5, k % 8, k >= 5 ? 3 : 0, k >= 8 ? 3 : 0, int'(k == 5), int'(k == 8));
      end
      check("down tick_a", 32'(tick_a), 1);
      mode = 2'b11; load_val = 2'd2;
      step();
      chk_cnt("load on tick", 0, 2, 2, 2, 0, 0);
      load_val = 2'd3;
      step();
      mode = 2'b00;
      step(); step(); step();
      chk_cnt("pre clear", 4, 6, 3, 3, 0, 0);
      check("pre clear tick_a", 32'(tick_a), 1);
      clear = 1'b1; add_a = 4'd2; add_b = 4'd3; add_valid = 1'b1;
      step();
      chk_cnt("clear on tick", 0, 0, 0, 0, 0, 0);
      check("clear sum", 32'(sum_a), 5);
      check("clear sv", 32'(sv_a), 1);
      clear = 1'b0; add_valid = 1'b0; mode = 2'b10;
      for (int k = 0; k < 4; k++) step();
      check("term tick", 32'(tick_a), 1);
      en = 1'b0;
      #1 check("term en0 tick", 32'(tick_a), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
